// File: rtl/mod_n_counter.sv
// mod_n_counter: prescaled up/down modulo-N counter with terminal-count and sticky overflow flags.
// Define MOD_N_COUNTER_SAT_EN to saturate at the boundary instead of wrapping.
module mod_n_counter #(
  parameter int WIDTH    = 5,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  logic [WIDTH-1:0] count_q, count_d, step_val;
  logic [PW-1:0] pre_q, pre_d;
  logic ovf_q, ovf_d, tick, at_top, at_bot, wrap;
  always_comb begin
    // reset in tick keeps tc low while the counter is held in reset
    tick = reset & en & (pre_q == PMAX);
    at_top = count_q == MAX;
    at_bot = count_q == '0;
    wrap = up_dn ? at_top : at_bot;
    tc = tick & wrap;
`ifdef MOD_N_COUNTER_SAT_EN
    step_val = wrap ? count_q : (up_dn ? count_q + 1'b1 : count_q - 1'b1);
`else
    step_val = up_dn ? (at_top ? '0 : count_q + 1'b1) : (at_bot ? MAX : count_q - 1'b1);
`endif
    count_d = clr ? '0 : load ? (load_val > MAX ? MAX : load_val) : tick ? step_val : count_q;
    pre_d = (clr | load) ? '0 : en ? (pre_q == PMAX ? '0 : pre_q + 1'b1) : pre_q;
    ovf_d = clr ? 1'b0 : ovf_q | tc;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      count_q <= '0;
      pre_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pre_q <= pre_d;
      ovf_q <= ovf_d;
    end
  assign count = count_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_mod_n_counter.sv
// tb_mod_n_counter: directed scoreboard bench for mod_n_counter (default and MOD_N_COUNTER_SAT_EN builds).
module tb_mod_n_counter;
  logic clk = 1'b0, reset = 1'b0, up_dn = 1'b0, clr = 1'b0, load = 1'b0;
  logic en16 = 1'b0, en10 = 1'b0, en3 = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] cnt16, cnt10, cnt3;
  logic tc16, tc10, tc3, ovf16, ovf10, ovf3;
  int checks = 0, errors = 0;
  typedef struct {string tag; logic [31:0] e;} exp_t;
  exp_t sb[$];
  int dn_seq[11] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
  always #5 clk = ~clk;
  mod_n_counter #(.WIDTH(5), .MODULUS(16), .PRESCALE(1)) u16 (
    .clk(clk), .reset(reset), .en(en16), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt16), .tc(tc16), .ovf(ovf16));
  mod_n_counter #(.WIDTH(5), .MODULUS(10), .PRESCALE(1)) u10 (
    .clk(clk), .reset(reset), .en(en10), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt10), .tc(tc10), .ovf(ovf10));
  mod_n_counter #(.WIDTH(5), .MODULUS(16), .PRESCALE(3)) u3 (
    .clk(clk), .reset(reset), .en(en3), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt3), .tc(tc3), .ovf(ovf3));
  task automatic exp_push(input string tag, input logic [31:0] e);
    sb.push_back('{tag, e});
  endtask
  task automatic obs_pop(input logic [31:0] obs);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", x.tag, obs, x.e);
      end
    end
  endtask
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    en16 = 1'b1;
    #1;
    exp_push("rst_tc_held", 32'(0)); obs_pop(32'(tc16));
    clk_step();
    exp_push("rst_count", 32'(0)); obs_pop(32'(cnt16));
    exp_push("rst_ovf", 32'(0)); obs_pop(32'(ovf16));
    exp_push("rst_count10", 32'(0)); obs_pop(32'(cnt10));
    exp_push("rst_count3", 32'(0)); obs_pop(32'(cnt3));
    reset = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_push("up_tc", 32'(i == 15)); obs_pop(32'(tc16));
      clk_step();
      exp_push("up_count", 32'((i + 1) % 16)); obs_pop(32'(cnt16));
      exp_push("up_ovf", 32'(i == 15)); obs_pop(32'(ovf16));
    end
    en16 = 1'b0;
    up_dn = 1'b0;
    en10 = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      exp_push("dn_tc", 32'(i == 0 || i == 10)); obs_pop(32'(tc10));
      clk_step();
      exp_push("dn_count", 32'(dn_seq[i])); obs_pop(32'(cnt10));
    end
    en10 = 1'b0;
    up_dn = 1'b1;
    en3 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      clk_step();
      exp_push("pre_count", 32'((i + 1) / 3)); obs_pop(32'(cnt3));
    end
    clk_step();
    exp_push("pre_mid", 32'(3)); obs_pop(32'(cnt3));
    en3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clk_step();
      exp_push("pre_hold", 32'(3)); obs_pop(32'(cnt3));
    end
    en3 = 1'b1;
    clk_step();
    exp_push("pre_delayed_no_step", 32'(3)); obs_pop(32'(cnt3));
    clk_step();
    exp_push("pre_delayed_step", 32'(4)); obs_pop(32'(cnt3));
    en3 = 1'b0;
    clr = 1'b1; load = 1'b1; load_val = 5'd7; en16 = 1'b1;
    clk_step();
    exp_push("prio_clr_count", 32'(0)); obs_pop(32'(cnt16));
    exp_push("prio_clr_ovf", 32'(0)); obs_pop(32'(ovf16));
    clr = 1'b0; load_val = 5'd20;
    clk_step();
    exp_push("load_clamp", 32'(15)); obs_pop(32'(cnt16));
    en16 = 1'b0; load_val = 5'd5;
    clk_step();
    exp_push("load_plain", 32'(5)); obs_pop(32'(cnt16));
    exp_push("load_ovf_kept", 32'(0)); obs_pop(32'(ovf16));
    load_val = 5'd15;
    clk_step();
    load = 1'b0; en16 = 1'b1;
    clk_step();
    exp_push("ovf_setup_count", 32'(0)); obs_pop(32'(cnt16));
    exp_push("ovf_setup_ovf", 32'(1)); obs_pop(32'(ovf16));
    en16 = 1'b0; load = 1'b1; load_val = 5'd9;
    clk_step();
    load = 1'b0; en3 = 1'b1;
    clk_step();
    exp_push("pre_reset_count", 32'(9)); obs_pop(32'(cnt16));
    up_dn = 1'b0; en16 = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    exp_push("async_count", 32'(0)); obs_pop(32'(cnt16));
    exp_push("async_tc", 32'(0)); obs_pop(32'(tc16));
    exp_push("async_ovf", 32'(0)); obs_pop(32'(ovf16));
    exp_push("async_count3", 32'(0)); obs_pop(32'(cnt3));
    clk_step();
    reset = 1'b1; up_dn = 1'b1; en16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_step();
      exp_push("post_reset_pre", 32'(i == 2)); obs_pop(32'(cnt3));
    end
    en3 = 1'b0; en16 = 1'b1;
    repeat (15) clk_step();
    exp_push("reach_top", 32'(15)); obs_pop(32'(cnt16));
    for (int i = 0; i < 3; i++) begin
      #1;
`ifdef MOD_N_COUNTER_SAT_EN
      exp_push("sat_tc", 32'(1)); obs_pop(32'(tc16));
      clk_step();
      exp_push("sat_count", 32'(15)); obs_pop(32'(cnt16));
`else
      exp_push("wrap_tc", 32'(i == 0)); obs_pop(32'(tc16));
      clk_step();
      exp_push("wrap_count", 32'(i)); obs_pop(32'(cnt16));
`endif
    end
    exp_push("boundary_ovf", 32'(1)); obs_pop(32'(ovf16));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
